bcd_convert_seq: RTL and testbench

Sequential, parametrised binary-to-BCD converter for the calculator datapath. It uses the shift-and-add-3 (double-dabble) algorithm, one bit per clock, so a single add-3 stage per digit is reused across all iterations. It sits between the ALU result register and the seven-segment display driver. Over the single-cell form it adds:
- configurable binary width and digit count;
- optional two's-complement input;
- an overflow flag;
- a start/busy/done handshake.

---
 rtl/bcd_convert_seq_if.sv | 16 +
 rtl/bcd_convert_seq.sv | 111 +++++++++++
 tb/tb_bcd_convert_seq.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/bcd_convert_seq_if.sv
// Start/busy/done handshake and result bus between the ALU result path and the BCD converter.
interface bcd_convert_seq_if #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DIGITS = 5
);
    logic                  start;
    logic [WIDTH-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  neg;
    logic                  ovf;

    modport master (output start, bin, input busy, done, bcd, neg, ovf);
    modport slave  (input start, bin, output busy, done, bcd, neg, ovf);
endinterface

// File: rtl/bcd_convert_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock, with
// optional two's-complement input, overflow flag and start/busy/done handshake.
module bcd_convert_seq #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DIGITS = 5,
    parameter bit          SIGNED = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    bcd_convert_seq_if.slave  bus
);
    localparam int unsigned BW = 4 * DIGITS;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] mag, mag_n;
    logic [BW-1:0]    work, work_n, adj;
    logic [CW-1:0]    cnt, cnt_n;
    logic             ovf_acc, ovf_acc_n;
    logic             sign, sign_n;
    logic             busy_n, done_n, neg_n, ovf_n;
    logic [BW-1:0]    bcd_n;

    // Add-3 correction applied to every working digit above 4 before the shift.
    always_comb begin
        adj = work;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (work[4*i +: 4] > 4'd4) begin
                adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
            end
        end
    end

    // Next-state, datapath and registered-output next values.
    always_comb begin
        state_n   = state;
        mag_n     = mag;
        work_n    = work;
        cnt_n     = cnt;
        ovf_acc_n = ovf_acc;
        sign_n    = sign;
        done_n    = 1'b0;
        bcd_n     = bus.bcd;
        neg_n     = bus.neg;
        ovf_n     = bus.ovf;

        unique case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    sign_n    = SIGNED & bus.bin[WIDTH-1];
                    mag_n     = sign_n ? (~bus.bin + WIDTH'(1)) : bus.bin;
                    work_n    = '0;
                    cnt_n     = CW'(WIDTH);
                    ovf_acc_n = 1'b0;
                    state_n   = SHIFT;
                end else begin
                    state_n   = IDLE;
                end
            end
            SHIFT: begin
                work_n    = {adj[BW-2:0], mag[WIDTH-1]};
                mag_n     = {mag[WIDTH-2:0], 1'b0};
                ovf_acc_n = ovf_acc | adj[BW-1];
                cnt_n     = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                    bcd_n   = work_n;
                    neg_n   = sign;
                    ovf_n   = ovf_acc_n;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

    // State, working and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            mag      <= '0;
            work     <= '0;
            cnt      <= '0;
            ovf_acc  <= 1'b0;
            sign     <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.bcd  <= '0;
            bus.neg  <= 1'b0;
            bus.ovf  <= 1'b0;
        end else begin
            state    <= state_n;
            mag      <= mag_n;
            work     <= work_n;
            cnt      <= cnt_n;
            ovf_acc  <= ovf_acc_n;
            sign     <= sign_n;
            bus.busy <= busy_n;
            bus.done <= done_n;
            bus.bcd  <= bcd_n;
            bus.neg  <= neg_n;
            bus.ovf  <= ovf_n;
        end
    end
endmodule

// File: tb/tb_bcd_convert_seq.sv
// Directed bench for bcd_convert_seq: unsigned 16/5, signed 16/5 and unsigned 10/3 instances.
module tb_bcd_convert_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] bin;
    int          sel;

    int n_checks = 0;
    int n_fail   = 0;

    logic        done_m, busy_m, neg_m, ovf_m;
    logic [19:0] bcd_m;

    bcd_convert_seq_if #(.WIDTH(16), .DIGITS(5)) if_a ();
    bcd_convert_seq_if #(.WIDTH(16), .DIGITS(5)) if_b ();
    bcd_convert_seq_if #(.WIDTH(10), .DIGITS(3)) if_c ();

    bcd_convert_seq #(.WIDTH(16), .DIGITS(5), .SIGNED(1'b0)) u_a (.clk(clk), .rst(rst), .bus(if_a));
    bcd_convert_seq #(.WIDTH(16), .DIGITS(5), .SIGNED(1'b1)) u_b (.clk(clk), .rst(rst), .bus(if_b));
    bcd_convert_seq #(.WIDTH(10), .DIGITS(3), .SIGNED(1'b0)) u_c (.clk(clk), .rst(rst), .bus(if_c));

    always #5 clk = ~clk;

    assign if_a.start = start & (sel == 0);
    assign if_b.start = start & (sel == 1);
    assign if_c.start = start & (sel == 2);
    assign if_a.bin   = bin;
    assign if_b.bin   = bin;
    assign if_c.bin   = bin[9:0];

    // Observe the selected instance.
    always_comb begin
        case (sel)
            1: begin
                done_m = if_b.done; busy_m = if_b.busy; neg_m = if_b.neg;
                ovf_m = if_b.ovf; bcd_m = if_b.bcd;
            end
            2: begin
                done_m = if_c.done; busy_m = if_c.busy; neg_m = if_c.neg;
                ovf_m = if_c.ovf; bcd_m = 20'(if_c.bcd);
            end
            default: begin
                done_m = if_a.done; busy_m = if_a.busy; neg_m = if_a.neg;
                ovf_m = if_a.ovf; bcd_m = if_a.bcd;
            end
        endcase
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for done; count busy cycles and whether bcd held steady meanwhile.
    task automatic wait_done(input int limit, output int lat, output int busy_cnt, output bit held);
        logic [19:0] b0;
        b0 = bcd_m;
        lat = 0;
        busy_cnt = 0;
        held = 1'b1;
        while (!done_m && lat < limit) begin
            if (busy_m) busy_cnt++;
            if (bcd_m !== b0) held = 1'b0;
            tick();
            lat++;
        end
        if (done_m && busy_m) busy_cnt++;
        check_eq("done_seen", 32'(done_m), 32'd1);
    endtask

    task automatic conv(input int s, input logic [15:0] v, output int lat, output int busy_cnt,
                        output bit held);
        sel = s;
        bin = v;
        start = 1'b1;
        tick();
        start = 1'b0;
        bin = ~v;
        wait_done(100, lat, busy_cnt, held);
    endtask

    int lat, bc, dones;
    bit held;

    initial begin
        rst = 1'b1; start = 1'b0; bin = '0; sel = 0;
        tick(); tick();
        check_eq("rst_busy", 32'(busy_m), 32'd0);
        check_eq("rst_done", 32'(done_m), 32'd0);
        check_eq("rst_bcd",  32'(bcd_m),  32'd0);
        check_eq("rst_neg",  32'(neg_m),  32'd0);
        check_eq("rst_ovf",  32'(ovf_m),  32'd0);
        rst = 1'b0;
        tick();

        // Unsigned 16-bit / 5 digits
        conv(0, 16'hFFFF, lat, bc, held);
        check_eq("ffff_bcd", 32'(bcd_m), 32'h65535);
        check_eq("ffff_neg", 32'(neg_m), 32'd0);
        check_eq("ffff_ovf", 32'(ovf_m), 32'd0);
        check_eq("ffff_lat", 32'(lat), 32'd16);
        check_eq("ffff_busy_cycles", 32'(bc), 32'd17);
        tick();
        check_eq("ffff_done_pulse", 32'(done_m), 32'd0);
        check_eq("ffff_busy_drop", 32'(busy_m), 32'd0);
        check_eq("ffff_bcd_hold", 32'(bcd_m), 32'h65535);

        conv(0, 16'd0, lat, bc, held);
        check_eq("zero_bcd", 32'(bcd_m), 32'h0);
        check_eq("zero_ovf", 32'(ovf_m), 32'd0);
        conv(0, 16'd9999, lat, bc, held);
        check_eq("d9999_bcd", 32'(bcd_m), 32'h09999);
        tick();
        conv(0, 16'd10, lat, bc, held);
        check_eq("d10_bcd", 32'(bcd_m), 32'h00010);
        check_eq("d10_held_prev", 32'(held), 32'd1);
        tick();

        // Signed 16-bit
        conv(1, 16'h8000, lat, bc, held);
        check_eq("s8000_neg", 32'(neg_m), 32'd1);
        check_eq("s8000_bcd", 32'(bcd_m), 32'h32768);
        check_eq("s8000_ovf", 32'(ovf_m), 32'd0);
        tick();
        conv(1, 16'hFFFF, lat, bc, held);
        check_eq("sffff_neg", 32'(neg_m), 32'd1);
        check_eq("sffff_bcd", 32'(bcd_m), 32'h00001);
        tick();
        conv(1, 16'h7FFF, lat, bc, held);
        check_eq("s7fff_neg", 32'(neg_m), 32'd0);
        check_eq("s7fff_bcd", 32'(bcd_m), 32'h32767);
        tick();

        // Unsigned 10-bit / 3 digits
        conv(2, 16'd999, lat, bc, held);
        check_eq("w10_999_bcd", 32'(bcd_m), 32'h999);
        check_eq("w10_999_ovf", 32'(ovf_m), 32'd0);
        check_eq("w10_lat", 32'(lat), 32'd10);
        tick();
        conv(2, 16'd1000, lat, bc, held);
        check_eq("w10_1000_bcd", 32'(bcd_m), 32'h000);
        check_eq("w10_1000_ovf", 32'(ovf_m), 32'd1);
        tick();
        conv(2, 16'd1023, lat, bc, held);
        check_eq("w10_1023_bcd", 32'(bcd_m), 32'h023);
        check_eq("w10_1023_ovf", 32'(ovf_m), 32'd1);
        tick();

        // Handshake: start while busy is ignored, start in DONE is accepted
        sel = 0;
        bin = 16'd1234; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        bin = 16'd5678; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(100, lat, bc, held);
        check_eq("hs_first_bcd", 32'(bcd_m), 32'h01234);
        check_eq("hs_first_lat", 32'(lat), 32'd12);
        bin = 16'd42; start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("hs_b2b_done_low", 32'(done_m), 32'd0);
        check_eq("hs_b2b_busy", 32'(busy_m), 32'd1);
        wait_done(100, lat, bc, held);
        check_eq("hs_second_bcd", 32'(bcd_m), 32'h00042);
        check_eq("hs_second_lat", 32'(lat), 32'd16);
        tick();

        // Reset mid-conversion
        bin = 16'd4321; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        rst = 1'b1;
        tick();
        check_eq("midrst_busy", 32'(busy_m), 32'd0);
        check_eq("midrst_done", 32'(done_m), 32'd0);
        check_eq("midrst_bcd",  32'(bcd_m),  32'd0);
        check_eq("midrst_ovf",  32'(ovf_m),  32'd0);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            if (done_m) dones++;
            tick();
        end
        check_eq("midrst_no_done", 32'(dones), 32'd0);
        conv(0, 16'd7, lat, bc, held);
        check_eq("post_rst_bcd", 32'(bcd_m), 32'h00007);
        check_eq("post_rst_lat", 32'(lat), 32'd16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
